// File: rtl/wide_alu_pkg.sv
// Shared definitions for the WIDE_ALU AXI window.
// Register offsets, state encodings and the byte-strobe merge helper.
package wide_alu_pkg;

    localparam logic [11:0] OFS_OP_A   = 12'h000;
    localparam logic [11:0] OFS_OP_B   = 12'h020;
    localparam logic [11:0] OFS_RES    = 12'h040;
    localparam logic [11:0] OFS_CTRL   = 12'h060;
    localparam logic [11:0] OFS_STATUS = 12'h064;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        E_IDLE,
        E_CALC,
        E_DONE
    } engine_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } axi_w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } axi_r_state_e;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] v;
        v = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) v[8*i +: 8] = new_v[8*i +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/wide_alu_core.sv
// Limb-serial ADD/SUB/XOR/AND engine, one 32-bit limb per cycle.
module wide_alu_core
    import wide_alu_pkg::*;
#(
    parameter int NR_LIMBS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [1:0]                i_op,
    input  logic [NR_LIMBS-1:0][31:0] i_op_a,
    input  logic [NR_LIMBS-1:0][31:0] i_op_b,
    output logic [NR_LIMBS-1:0][31:0] o_res,
    output logic                      o_carry,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_done_pulse
);
    localparam int KW = (NR_LIMBS > 1) ? $clog2(NR_LIMBS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NR_LIMBS - 1);

    engine_state_e             r_state, w_state_nxt;
    alu_op_e                   r_op;
    logic [KW-1:0]             r_k;
    logic                      r_c, r_carry, r_done;
    logic [NR_LIMBS-1:0][31:0] r_res;
    logic [31:0]               w_a, w_b, w_limb;
    logic [32:0]               w_sum;
    logic                      w_last, w_accept;

    assign w_a      = i_op_a[r_k];
    assign w_b      = (r_op == ALU_SUB) ? ~i_op_b[r_k] : i_op_b[r_k];
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b} + {32'd0, r_c};
    assign w_last   = (r_k == K_LAST);
    assign w_accept = i_start && (r_state != E_CALC);

    always_comb begin
        w_limb = w_sum[31:0];
        unique case (r_op)
            ALU_XOR: w_limb = w_a ^ i_op_b[r_k];
            ALU_AND: w_limb = w_a & i_op_b[r_k];
            default: w_limb = w_sum[31:0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            E_IDLE:  w_state_nxt = i_start ? E_CALC : E_IDLE;
            E_CALC:  w_state_nxt = w_last ? E_DONE : E_CALC;
            E_DONE:  w_state_nxt = i_start ? E_CALC : E_IDLE;
            default: w_state_nxt = E_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= E_IDLE;
            r_op    <= ALU_ADD;
            r_k     <= '0;
            r_c     <= 1'b0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= alu_op_e'(i_op);
                r_k     <= '0;
                // SUB is A + ~B + 1: the +1 enters as the first carry-in
                r_c     <= (alu_op_e'(i_op) == ALU_SUB);
                r_carry <= 1'b0;
                r_done  <= 1'b0;
            end else if (r_state == E_CALC) begin
                r_res[r_k] <= w_limb;
                r_k        <= r_k + 1'b1;
                r_c        <= w_sum[32];
                if (w_last) begin
                    r_done <= 1'b1;
                    unique case (r_op)
                        ALU_ADD: r_carry <= w_sum[32];
                        ALU_SUB: r_carry <= ~w_sum[32];
                        default: r_carry <= 1'b0;
                    endcase
                end
            end
        end
    end

    assign o_res        = r_res;
    assign o_carry      = r_carry;
    assign o_busy       = (r_state == E_CALC);
    assign o_done       = r_done;
    assign o_done_pulse = (r_state == E_DONE);

endmodule

// File: rtl/wide_alu_axi_slave.sv
// AXI4 register front-end for the WIDE_ALU window around wide_alu_core.
module wide_alu_axi_slave
    import wide_alu_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_USER_WIDTH = 6,
    parameter int NR_LIMBS       = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      i_slv_aw_valid,
    output logic                      o_slv_aw_ready,
    input  logic [AXI_ID_WIDTH-1:0]   i_slv_aw_id,
    input  logic [31:0]               i_slv_aw_addr,
    input  logic [7:0]                i_slv_aw_len,
    input  logic                      i_slv_w_valid,
    output logic                      o_slv_w_ready,
    input  logic [31:0]               i_slv_w_data,
    input  logic [3:0]                i_slv_w_strb,
    input  logic                      i_slv_w_last,
    output logic                      o_slv_b_valid,
    input  logic                      i_slv_b_ready,
    output logic [AXI_ID_WIDTH-1:0]   o_slv_b_id,
    output logic [1:0]                o_slv_b_resp,
    output logic [AXI_USER_WIDTH-1:0] o_slv_b_user,
    input  logic                      i_slv_ar_valid,
    output logic                      o_slv_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]   i_slv_ar_id,
    input  logic [31:0]               i_slv_ar_addr,
    input  logic [7:0]                i_slv_ar_len,
    output logic                      o_slv_r_valid,
    input  logic                      i_slv_r_ready,
    output logic [AXI_ID_WIDTH-1:0]   o_slv_r_id,
    output logic [31:0]               o_slv_r_data,
    output logic [1:0]                o_slv_r_resp,
    output logic                      o_slv_r_last,
    output logic [AXI_USER_WIDTH-1:0] o_slv_r_user,
    output logic                      done_irq_o
);
    axi_w_state_e              r_w_state, w_w_nxt;
    axi_r_state_e              r_r_state, w_r_nxt;
    logic                      r_live, r_werr;
    logic [AXI_ID_WIDTH-1:0]   r_wid, r_rid;
    logic [11:0]               r_waddr, r_raddr, w_ra;
    logic [7:0]                r_rlen, r_rcnt;
    logic [31:0]               r_rdata, w_rd_data;
    logic [1:0]                r_rresp, r_op;
    logic [NR_LIMBS-1:0][31:0] r_op_a, r_op_b, w_res;
    logic w_busy, w_done, w_carry, w_rd_err;
    logic w_aw_hs, w_wbeat, w_ar_hs, w_r_hs, w_rlast;
    logic w_sel_a, w_sel_b, w_sel_ctrl, w_werr, w_op_wr, w_start;
    logic w_unused;

    assign w_unused = ^{i_slv_aw_addr[31:12], i_slv_ar_addr[31:12],
                        i_slv_aw_len, w_ra[1:0]};

    // Readies stay low in reset and for the first cycle after release
    assign o_slv_aw_ready = r_live && (r_w_state == W_IDLE);
    assign o_slv_w_ready  = (r_w_state == W_DATA);
    assign o_slv_b_valid  = (r_w_state == W_RESP);
    assign o_slv_b_id     = r_wid;
    assign o_slv_b_resp   = r_werr ? RESP_SLVERR : RESP_OKAY;
    assign o_slv_b_user   = '0;
    assign o_slv_ar_ready = r_live && (r_r_state == R_IDLE);
    assign o_slv_r_valid  = (r_r_state == R_DATA);
    assign o_slv_r_id     = r_rid;
    assign o_slv_r_data   = r_rdata;
    assign o_slv_r_resp   = r_rresp;
    assign o_slv_r_last   = w_rlast;
    assign o_slv_r_user   = '0;

    assign w_aw_hs = o_slv_aw_ready && i_slv_aw_valid;
    assign w_wbeat = o_slv_w_ready && i_slv_w_valid;
    assign w_ar_hs = o_slv_ar_ready && i_slv_ar_valid;
    assign w_r_hs  = o_slv_r_valid && i_slv_r_ready;
    assign w_rlast = (r_rcnt == r_rlen);

    always_comb begin
        w_sel_a    = 1'b0;
        w_sel_b    = 1'b0;
        w_sel_ctrl = 1'b0;
        w_werr     = 1'b0;
        unique case (1'b1)
            (r_waddr[11:5] == OFS_OP_A[11:5]): begin
                w_sel_a = !w_busy;
                w_werr  = w_busy;
            end
            (r_waddr[11:5] == OFS_OP_B[11:5]): begin
                w_sel_b = !w_busy;
                w_werr  = w_busy;
            end
            (r_waddr[11:2] == OFS_CTRL[11:2]): begin
                w_sel_ctrl = 1'b1;
                // a START while busy is silently ignored; an OP-only write is not
                w_werr = w_busy && i_slv_w_strb[0] && !i_slv_w_data[0];
            end
            default: w_werr = 1'b1;
        endcase
    end

    assign w_op_wr = w_wbeat && w_sel_ctrl && i_slv_w_strb[0] && !w_busy;
    assign w_start = w_op_wr && i_slv_w_data[0];

    always_comb begin
        w_w_nxt = r_w_state;
        unique case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_nxt = W_DATA;
            W_DATA:  if (w_wbeat && i_slv_w_last) w_w_nxt = W_RESP;
            W_RESP:  if (i_slv_b_ready) w_w_nxt = W_IDLE;
            default: w_w_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_live    <= 1'b0;
            r_w_state <= W_IDLE;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_werr    <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op      <= '0;
        end else begin
            r_live    <= 1'b1;
            r_w_state <= w_w_nxt;
            if (w_aw_hs) begin
                r_wid   <= i_slv_aw_id;
                r_waddr <= i_slv_aw_addr[11:0];
                r_werr  <= 1'b0;
            end
            if (w_wbeat) begin
                r_waddr <= r_waddr + 12'd4;
                if (w_werr) r_werr <= 1'b1;
                if (w_sel_a)
                    r_op_a[r_waddr[4:2]] <= apply_strb(r_op_a[r_waddr[4:2]],
                                                       i_slv_w_data, i_slv_w_strb);
                if (w_sel_b)
                    r_op_b[r_waddr[4:2]] <= apply_strb(r_op_b[r_waddr[4:2]],
                                                       i_slv_w_data, i_slv_w_strb);
            end
            if (w_op_wr) r_op <= i_slv_w_data[2:1];
        end
    end

    assign w_ra = (r_r_state == R_IDLE) ? i_slv_ar_addr[11:0] : r_raddr;

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        unique case (1'b1)
            (w_ra[11:5] == OFS_OP_A[11:5]):   w_rd_data = r_op_a[w_ra[4:2]];
            (w_ra[11:5] == OFS_OP_B[11:5]):   w_rd_data = r_op_b[w_ra[4:2]];
            (w_ra[11:5] == OFS_RES[11:5]):    w_rd_data = w_res[w_ra[4:2]];
            (w_ra[11:2] == OFS_CTRL[11:2]):   w_rd_data = {29'd0, r_op, 1'b0};
            (w_ra[11:2] == OFS_STATUS[11:2]): w_rd_data = {29'd0, w_carry, w_done, w_busy};
            default: w_rd_err = 1'b1;
        endcase
    end

    always_comb begin
        w_r_nxt = r_r_state;
        unique case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_rlast) w_r_nxt = R_IDLE;
            default: w_r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r_state <= R_IDLE;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_r_state <= w_r_nxt;
            if (w_ar_hs || (w_r_hs && !w_rlast)) begin
                r_raddr <= w_ra + 12'd4;
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_ar_hs) begin
                r_rid  <= i_slv_ar_id;
                r_rlen <= i_slv_ar_len;
                r_rcnt <= '0;
            end else if (w_r_hs && !w_rlast) begin
                r_rcnt <= r_rcnt + 8'd1;
            end
        end
    end

    wide_alu_core #(
        .NR_LIMBS(NR_LIMBS)
    ) u_core (
        .i_clk       (clk_i),
        .i_rst_n     (rst_ni),
        .i_start     (w_start),
        .i_op        (i_slv_w_data[2:1]),
        .i_op_a      (r_op_a),
        .i_op_b      (r_op_b),
        .o_res       (w_res),
        .o_carry     (w_carry),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_done_pulse(done_irq_o)
    );

endmodule
